// File: rtl/fixed_to_float_fsm.sv
// Multi-cycle signed fixed-point to {sign, exponent, mantissa} float converter with a valid/ready handshake.
// Define FIXED_TO_FLOAT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fixed_to_float_fsm #(
  parameter int IN_WIDTH  = 32,
  parameter int FRAC_BITS = 0,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                         i_CLK,
  input  logic                         i_RESET_N,
  input  logic                         i_VALID,
  input  logic [IN_WIDTH-1:0]          i_INPUT,
  output logic                         o_READY,
  output logic                         o_DONE,
  output logic [EXP_WIDTH+MAN_WIDTH:0] o_OUTPUT
);

  localparam int BIAS  = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EXT_W = EXP_WIDTH + 2;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int FW    = IN_WIDTH + MAN_WIDTH;
  localparam logic [EXT_W-1:0] EXP_BASE = EXT_W'(BIAS + IN_WIDTH - 1 - FRAC_BITS);

  generate
    if ((IN_WIDTH < 2) || (FRAC_BITS < 0) || (FRAC_BITS >= IN_WIDTH) ||
        (BIAS - FRAC_BITS < 1) ||
        (BIAS + IN_WIDTH - FRAC_BITS > (1 << EXP_WIDTH) - 2)) begin : g_illegal_params
      $error("fixed_to_float_fsm: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, PACK} state_t;

  state_t               state;
  logic [IN_WIDTH-1:0]  in_reg;
  logic [IN_WIDTH-1:0]  mag;
  logic                 sign;
  logic                 zero;
  logic [CNT_W-1:0]     count;
  logic [EXP_WIDTH-1:0] exp_reg;
  logic [MAN_WIDTH-1:0] man_reg;

  // Bits below the leading one, left-aligned; the zero tail pads short inputs.
  logic [FW-1:0]        frac;
  logic [EXT_W-1:0]     exp_ext;
  logic [MAN_WIDTH-1:0] man_next;
  logic [EXP_WIDTH-1:0] exp_next;

  assign frac    = {mag[IN_WIDTH-2:0], {(MAN_WIDTH + 1){1'b0}}};
  assign exp_ext = EXP_BASE - EXT_W'(count);

`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 round_up;
  logic [MAN_WIDTH-1:0] man_trunc;
  logic [MAN_WIDTH:0]   man_sum;
  logic [EXT_W-1:0]     exp_rnd;

  assign man_trunc  = frac[FW-1:IN_WIDTH];
  assign guard_bit  = frac[IN_WIDTH-1];
  assign sticky_bit = |frac[IN_WIDTH-2:0];
  assign round_up   = guard_bit & (sticky_bit | man_trunc[0]);
  assign man_sum    = {1'b0, man_trunc} + {{MAN_WIDTH{1'b0}}, round_up};
  // A carry out of the mantissa means 1.111..1 rounded up to 10.000..0.
  assign man_next   = man_sum[MAN_WIDTH] ? '0 : man_sum[MAN_WIDTH-1:0];
  assign exp_rnd    = exp_ext + EXT_W'(man_sum[MAN_WIDTH]);
  assign exp_next   = EXP_WIDTH'(exp_rnd);
`else
  assign man_next   = MAN_WIDTH'(frac >> IN_WIDTH);
  assign exp_next   = EXP_WIDTH'(exp_ext);
`endif

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state    <= IDLE;
      in_reg   <= '0;
      mag      <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      count    <= '0;
      exp_reg  <= '0;
      man_reg  <= '0;
      o_READY  <= 1'b1;
      o_DONE   <= 1'b0;
      o_OUTPUT <= '0;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (i_VALID && o_READY) begin
            in_reg  <= i_INPUT;
            sign    <= i_INPUT[IN_WIDTH-1];
            count   <= '0;
            zero    <= 1'b0;
            o_READY <= 1'b0;
            state   <= ABS;
          end
        end
        ABS: begin
          // Unsigned negate so the most negative input maps to 2^(IN_WIDTH-1).
          mag <= sign ? (~in_reg + IN_WIDTH'(1)) : in_reg;
          if (in_reg == '0) begin
            zero  <= 1'b1;
            state <= PACK;
          end else begin
            state <= NORM;
          end
        end
        NORM: begin
          if (mag[IN_WIDTH-1]) begin
            state <= ROUND;
          end else begin
            mag   <= mag << 1;
            count <= count + CNT_W'(1);
          end
        end
        ROUND: begin
          exp_reg <= exp_next;
          man_reg <= man_next;
          state   <= PACK;
        end
        PACK: begin
          o_OUTPUT <= zero ? '0 : {sign, exp_reg, man_reg};
          o_DONE   <= 1'b1;
          o_READY  <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          o_READY <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_float_fsm.sv
// Scoreboard bench for fixed_to_float_fsm: default (integer) and FRAC_BITS=16 instances, directed vectors.
// Expected values depend on FIXED_TO_FLOAT_ROUND_NEAREST_EN where rounding matters.
module tb_fixed_to_float_fsm;

  typedef struct {
    logic [31:0] value;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid0, valid1;
  logic [31:0] in0, in1;
  logic        ready0, ready1, done0, done1;
  logic [31:0] out0, out1;

  exp_t sb0[$];
  exp_t sb1[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   failures = 0;
  int   pushes0 = 0, pushes1 = 0;
  int   dones0  = 0, dones1  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_to_float_fsm #(.IN_WIDTH(32), .FRAC_BITS(0), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut0 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_VALID(valid0), .i_INPUT(in0),
    .o_READY(ready0), .o_DONE(done0), .o_OUTPUT(out0));

  fixed_to_float_fsm #(.IN_WIDTH(32), .FRAC_BITS(16), .EXP_WIDTH(8), .MAN_WIDTH(23)) dut1 (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_VALID(valid1), .i_INPUT(in1),
    .o_READY(ready1), .o_DONE(done1), .o_OUTPUT(out1));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor side: pop the oldest expectation whenever a unit pulses o_DONE.
  task automatic checkDone(input int unit, input logic [31:0] actual);
    exp_t e;
    int   empty;
    empty = (unit == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
    if (empty != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_done unit%0d: got 0x%08h expected no pulse", unit, actual);
    end else begin
      e = (unit == 0) ? sb0.pop_front() : sb1.pop_front();
      checkOutput({e.name, "_value"}, actual, e.value);
      checkOutput({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin
      dones0++;
      checkDone(0, out0);
    end
    if (done1) begin
      dones1++;
      checkDone(1, out1);
    end
  end

  // Stimulus side: wait for ready, present the word for one edge, then scramble the input.
  task automatic applyStimulus(input int unit, input logic [31:0] val, input logic [31:0] expv,
                               input int lat, input string name, input bit hold, input bit track);
    int   waited = 0;
    exp_t e;
    while (((unit == 0) ? ready0 : ready1) !== 1'b1 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_ready_timeout: got ready=0 expected ready=1", name);
      return;
    end
    if (unit == 0) begin
      valid0 = 1'b1;
      in0    = val;
    end else begin
      valid1 = 1'b1;
      in1    = val;
    end
    if (track) begin
      e.value = expv;
      e.lat   = lat;
      e.acc   = cyc + 1;
      e.name  = name;
      if (unit == 0) begin
        sb0.push_back(e);
        pushes0++;
      end else begin
        sb1.push_back(e);
        pushes1++;
      end
    end
    @(posedge clk);
    #1;
    if (unit == 0) begin
      in0 = ~val ^ 32'h5A5A_0F0F;
      if (!hold) valid0 = 1'b0;
    end else begin
      in1 = ~val ^ 32'h5A5A_0F0F;
      if (!hold) valid1 = 1'b0;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb0.size() + sb1.size());
    end
  endtask

  initial begin
    valid0 = 1'b0;
    valid1 = 1'b0;
    in0    = '0;
    in1    = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready0), 32'd1);
    checkOutput("reset_done", 32'(done0), 32'd0);
    checkOutput("reset_output", out0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 32'h0000_0001, 32'h3F80_0000, 35, "one", 1'b0, 1'b1);
    applyStimulus(0, 32'hFFFF_FFFF, 32'hBF80_0000, 35, "minus_one", 1'b0, 1'b1);
    applyStimulus(0, 32'h0000_0000, 32'h0000_0000, 2, "zero", 1'b0, 1'b1);
    applyStimulus(0, 32'h8000_0000, 32'hCF00_0000, 4, "most_negative", 1'b0, 1'b1);
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
    applyStimulus(0, 32'h7FFF_FFFF, 32'h4F00_0000, 5, "max_positive", 1'b0, 1'b1);
    applyStimulus(0, 32'h0100_0003, 32'h4B80_0002, 11, "tie_even", 1'b0, 1'b1);
`else
    applyStimulus(0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 5, "max_positive", 1'b0, 1'b1);
    applyStimulus(0, 32'h0100_0003, 32'h4B80_0001, 11, "tie_even", 1'b0, 1'b1);
`endif
    drain();

    applyStimulus(0, 32'h0000_0005, 32'h40A0_0000, 33, "stream0", 1'b1, 1'b1);
    applyStimulus(0, 32'hFFFF_FFFD, 32'hC040_0000, 34, "stream1", 1'b1, 1'b1);
    applyStimulus(0, 32'h0010_0000, 32'h4980_0000, 15, "stream2", 1'b0, 1'b1);
    valid0 = 1'b0;

    applyStimulus(1, 32'h0001_8000, 32'h3FC0_0000, 19, "q16_one_half", 1'b0, 1'b1);
    applyStimulus(1, 32'hFFFF_0000, 32'hBF80_0000, 19, "q16_minus_one", 1'b0, 1'b1);
    drain();
    checkOutput("done_count_unit0", 32'(dones0), 32'(pushes0));
    checkOutput("done_count_unit1", 32'(dones1), 32'(pushes1));

    // Abort a conversion deep in normalisation; its result must never appear.
    applyStimulus(0, 32'h0000_0001, 32'h0, 0, "aborted", 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midnorm_reset_ready", 32'(ready0), 32'd1);
    checkOutput("midnorm_reset_done", 32'(done0), 32'd0);
    checkOutput("midnorm_reset_output", out0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 32'h0000_0002, 32'h4000_0000, 34, "after_reset", 1'b0, 1'b1);
    drain();
    repeat (40) @(posedge clk);
    #1;
    checkOutput("final_done_count_unit0", 32'(dones0), 32'(pushes0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fixed_to_float_fsm.md
Name: fixed_to_float_fsm

Overview:
- Multi-cycle signed fixed-point to IEEE-754-style floating-point converter.
- Parametrised successor to the single-precision integer-only converter FSM.
- Adds configurable input width, fractional bits, and exponent/mantissa widths; a valid/ready handshake; correct two's-complement magnitude; exact zero handling.
- Sits between fixed-point datapaths (filters, accumulators) and float consumers.

Parameters:
- IN_WIDTH, 32: signed input width, two's complement, >= 2.
- FRAC_BITS, 0: number of input bits right of the binary point, 0 <= FRAC_BITS < IN_WIDTH.
- EXP_WIDTH, 8: exponent field width. BIAS = 2^(EXP_WIDTH-1)-1.
- MAN_WIDTH, 23: stored mantissa width (hidden bit excluded).
- Legal set: BIAS - FRAC_BITS >= 1 and BIAS + IN_WIDTH - FRAC_BITS <= 2^EXP_WIDTH-2. Other sets are illegal; an elaboration-time check is required.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RESET_N  in  1  asynchronous active-low reset.
- i_VALID  in  1  input word present.
- i_INPUT  in  IN_WIDTH  signed fixed-point word.
- o_READY  out  1  block idle and accepting.
- o_DONE  out  1  one-cycle pulse, o_OUTPUT updated.
- o_OUTPUT  out  1+EXP_WIDTH+MAN_WIDTH  {sign, exponent, mantissa}.

Behaviour:
- Reset values:
  - state=IDLE, o_READY=1, o_DONE=0, o_OUTPUT=0.
  - Internal magnitude/count registers are cleared.
- Reset mid-operation aborts immediately. The partial result is never presented.
- Accept: a rising edge with state=IDLE, o_READY=1 and i_VALID=1. On that edge:
  - Latch i_INPUT and the sign (i_INPUT MSB).
  - Clear the shift count, set o_READY=0, go to ABS.
- i_VALID is ignored while o_READY=0. There is no buffering.
- States:
  - IDLE: wait for accept.
  - ABS: mag <= sign ? (~in + 1) : in, computed as an IN_WIDTH-bit unsigned value, so -2^(IN_WIDTH-1) yields 2^(IN_WIDTH-1) exactly. If the magnitude is 0, go to PACK with the zero flag set; else go to NORM.
  - NORM: if mag MSB = 1, go to ROUND; else mag <= mag<<1 and count <= count+1, stay in NORM. One shift per cycle.
  - ROUND:
    - Mantissa = the MAN_WIDTH bits below the leading one. Zero-pad on the right if IN_WIDTH-1 < MAN_WIDTH.
    - Default is truncation.
    - exp = BIAS + (IN_WIDTH-1-FRAC_BITS) - count, computed at EXP_WIDTH+2 bits, then narrowed.
  - PACK: o_OUTPUT <= zero ? {sign=0, all zeros} : {sign, exp, mantissa}. o_DONE <= 1, o_READY <= 1, go to IDLE.
- o_DONE is high for exactly one cycle; it is cleared on the next edge.
- o_OUTPUT holds its value until the next PACK. It is not cleared in IDLE.
- Latency, with lz = leading zeros of the magnitude:
  - o_DONE rises lz+4 edges after the accept edge (ABS 1, NORM lz+1, ROUND 1, PACK 1).
  - Zero input: 2 edges.
  - Defaults, input 1: 35 edges.
- Back-to-back: a new accept is possible on the edge after PACK (o_READY=1 in the o_DONE cycle).
- Negative zero is never produced. Exponent overflow and underflow are impossible within legal parameters.
- Case statements have a default returning to IDLE, including unused state encodings.

Optional Feature:
- Macro: FIXED_TO_FLOAT_ROUND_NEAREST_EN.
- Defined: ROUND applies round-to-nearest, ties-to-even, using guard and sticky bits (all bits below the kept mantissa).
  - A mantissa carry-out clears the mantissa and increments exp by 1.
  - Still one ROUND cycle, so latency is unchanged.
- Undefined: truncation toward zero magnitude. Guard and sticky logic is absent.

Test Plan:
- Defaults:
  - Input 1 gives 0x3F800000 with o_DONE 35 edges after accept.
  - Input -1 gives 0xBF800000.
  - Input 0 gives 0x00000000 after 2 edges.
- Defaults, input 0x80000000 (-2^31): 0xCF000000. Input 0x7FFFFFFF: 0x4EFFFFFF when truncating; 0x4F000000 with the macro (carry into exponent).
- Defaults, input 0x01000003: 0x4B800001 when truncating; 0x4B800002 with the macro (tie to even).
- FRAC_BITS=16:
  - Input 0x00018000 (1.5) gives 0x3FC00000.
  - Input 0xFFFF0000 (-1.0) gives 0xBF800000.
- Handshake:
  - Hold i_VALID=1 with a stream of 3 words. Each is accepted only when o_READY=1.
  - Exactly 3 o_DONE pulses occur, with correct outputs in order. Changes on i_INPUT while busy have no effect.
- Reset:
  - Assert i_RESET_N=0 mid-NORM; all outputs go to reset values asynchronously.
  - After release, a fresh input 2 gives 0x40000000, with no stale o_DONE.
